// File: rtl/rpn_ctrl_if.sv
// Stack-side port of the RPN command sequencer: strobes and data toward the
// stack, output register and flags back from it.
interface rpn_ctrl_if #(
  parameter int W = 4
);
  logic         push;
  logic         pop;
  logic [W-1:0] din;
  logic [W-1:0] dout;
  logic         full;
  logic         empty;

  modport master (output push, pop, din, input dout, full, empty);
  modport slave  (input push, pop, din, output dout, full, empty);
endinterface

// File: rtl/rpn_ctrl.sv
// RPN command sequencer: turns PUSH/ADD/SUB/XOR key strobes into push/pop
// traffic on an external stack, with its own occupancy tracking.
module rpn_ctrl #(
  parameter  int DEPTH = 8,
  parameter  int W     = 4,
  localparam int LW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rstN,
  input  logic          key_valid,
  input  logic [1:0]    key_op,
  input  logic [W-1:0]  key_num,
  rpn_ctrl_if.master    stk,
  output logic          busy,
  output logic [LW-1:0] level,
  output logic [W-1:0]  result,
  output logic          result_valid,
  output logic          err,
  output logic [1:0]    err_code
);

  typedef enum logic [2:0] {IDLE, PUSH_LIT, POP1, POP2, CAP2, PUSH_RES} state_t;
  typedef enum logic [1:0] {OP_PUSH, OP_ADD, OP_SUB, OP_XOR} op_t;

  localparam logic [1:0] ERR_OVERFLOW  = 2'b01;
  localparam logic [1:0] ERR_UNDERFLOW = 2'b10;
  localparam logic [1:0] ERR_BUSY      = 2'b11;

  state_t       state;
  op_t          op_q;
  logic [W-1:0] opnd_b;

  // The stack flags are informational only; occupancy is tracked locally.
  logic unused_flags;
  assign unused_flags = &{1'b0, stk.full, stk.empty};

  function automatic logic [W-1:0] alu(input op_t op, input logic [W-1:0] a,
                                       input logic [W-1:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_XOR:  return a ^ b;
      default: return '0;
    endcase
  endfunction

  assign busy = (state != IDLE);

  // NOTE: every register here is written with <= so all updates see the
  // pre-edge values; mixing in = would make ordering inside the block matter.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state        <= IDLE;
      op_q         <= OP_PUSH;
      opnd_b       <= '0;
      level        <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      err          <= 1'b0;
      err_code     <= 2'b00;
      stk.push     <= 1'b0;
      stk.pop      <= 1'b0;
      stk.din      <= '0;
    end else begin
      stk.push     <= 1'b0;
      stk.pop      <= 1'b0;
      stk.din      <= '0;
      result_valid <= 1'b0;
      err          <= 1'b0;

      case (state)
        IDLE: begin
          if (key_valid) begin
            if (op_t'(key_op) == OP_PUSH) begin
              if (level == LW'(DEPTH)) begin
                err      <= 1'b1;
                err_code <= ERR_OVERFLOW;
              end else begin
                // stk.din doubles as the latched literal for the push cycle.
                stk.push <= 1'b1;
                stk.din  <= key_num;
                state    <= PUSH_LIT;
              end
            end else if (level < LW'(2)) begin
              err      <= 1'b1;
              err_code <= ERR_UNDERFLOW;
            end else begin
              op_q    <= op_t'(key_op);
              stk.pop <= 1'b1;
              state   <= POP1;
            end
          end
        end
        PUSH_LIT: begin
          level <= level + LW'(1);
          state <= IDLE;
        end
        POP1: begin
          level   <= level - LW'(1);
          stk.pop <= 1'b1;
          state   <= POP2;
        end
        POP2: begin
          level  <= level - LW'(1);
          opnd_b <= stk.dout;
          state  <= CAP2;
        end
        CAP2: begin
          // stk.dout now holds the deeper operand a.
          stk.push     <= 1'b1;
          stk.din      <= alu(op_q, stk.dout, opnd_b);
          result       <= alu(op_q, stk.dout, opnd_b);
          result_valid <= 1'b1;
          state        <= PUSH_RES;
        end
        PUSH_RES: begin
          level <= level + LW'(1);
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (state != IDLE && key_valid) begin
        err      <= 1'b1;
        err_code <= ERR_BUSY;
      end
    end
  end

endmodule

// File: tb/tb_rpn_ctrl.sv
// Self-checking bench for rpn_ctrl: behavioural stack in the environment and a
// queue-based reference model of stack contents, level and result.
module tb_rpn_ctrl;
  localparam int DEPTH = 8;
  localparam int W     = 4;

  logic       clk = 1'b0;
  logic       rstN = 1'b0;
  logic       key_valid = 1'b0;
  logic [1:0] key_op = 2'b00;
  logic [3:0] key_num = 4'h0;
  logic       busy;
  logic [3:0] level;
  logic [3:0] result;
  logic       result_valid;
  logic       err;
  logic [1:0] err_code;

  rpn_ctrl_if #(.W(W)) stk_bus ();

  rpn_ctrl #(.DEPTH(DEPTH), .W(W)) dut (
    .clk(clk), .rstN(rstN), .key_valid(key_valid), .key_op(key_op),
    .key_num(key_num), .stk(stk_bus), .busy(busy), .level(level),
    .result(result), .result_valid(result_valid), .err(err),
    .err_code(err_code)
  );

  always #5 clk = ~clk;

  // Environment stack: 8 deep, output register valid the cycle after a pop.
  logic [3:0] smem [DEPTH];
  int         sp;
  logic [3:0] sdout;
  always @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      sp    <= 0;
      sdout <= '0;
    end else if (stk_bus.push && sp < DEPTH) begin
      smem[sp] <= stk_bus.din;
      sp       <= sp + 1;
    end else if (stk_bus.pop && sp > 0) begin
      sdout <= smem[sp-1];
      sp    <= sp - 1;
    end
  end
  assign stk_bus.dout  = sdout;
  assign stk_bus.full  = (sp == DEPTH);
  assign stk_bus.empty = (sp == 0);

  // Reference model state.
  int q[$];
  int last_result;
  int last_code;
  int n_checks = 0;
  int n_pass   = 0;

  typedef struct packed {
    logic       busy, push, pop;
    logic [3:0] din, level;
    logic       rv, err;
    logic [3:0] result;
    logic [1:0] code;
  } obs_t;

  function automatic obs_t sample();
    return {busy, stk_bus.push, stk_bus.pop, stk_bus.din, level,
            result_valid, err, result, err_code};
  endfunction

  function automatic obs_t mk(input logic b, input logic pu, input logic po,
                              input int din, input int lvl, input logic rv,
                              input logic e, input int res, input int code);
    return {b, pu, po, 4'(din), 4'(lvl), rv, e, 4'(res), 2'(code)};
  endfunction

  function automatic int ref_op(input int op, input int a, input int b);
    case (op)
      1:       return (a + b) % 16;
      2:       return (a - b + 16) % 16;
      default: return a ^ b;
    endcase
  endfunction

  task automatic model_reset();
    q.delete();
    last_result = 0;
    last_code   = 0;
  endtask

  // Issues one command at a negedge and checks every cycle until the
  // controller can accept the next command; returns at that negedge.
  task automatic exec_cmd(input int op, input int num, input string tag);
    obs_t exp_q[$];
    obs_t obs;
    int   lvl, a, b, r;
    lvl = q.size();
    key_valid = 1'b1; key_op = 2'(op); key_num = 4'(num);
    @(negedge clk);
    key_valid = 1'b0;
    if (op == 0) begin
      if (lvl == DEPTH) begin
        last_code = 1;
        exp_q.push_back(mk(0, 0, 0, 0, lvl, 0, 1, last_result, last_code));
      end else begin
        exp_q.push_back(mk(1, 1, 0, num, lvl, 0, 0, last_result, last_code));
        exp_q.push_back(mk(0, 0, 0, 0, lvl + 1, 0, 0, last_result, last_code));
        q.push_back(num);
      end
    end else if (lvl < 2) begin
      last_code = 2;
      exp_q.push_back(mk(0, 0, 0, 0, lvl, 0, 1, last_result, last_code));
    end else begin
      b = q.pop_back();
      a = q.pop_back();
      r = ref_op(op, a, b);
      exp_q.push_back(mk(1, 0, 1, 0, lvl,     0, 0, last_result, last_code));
      exp_q.push_back(mk(1, 0, 1, 0, lvl - 1, 0, 0, last_result, last_code));
      exp_q.push_back(mk(1, 0, 0, 0, lvl - 2, 0, 0, last_result, last_code));
      exp_q.push_back(mk(1, 1, 0, r, lvl - 2, 1, 0, r, last_code));
      exp_q.push_back(mk(0, 0, 0, 0, lvl - 1, 0, 0, r, last_code));
      last_result = r;
      q.push_back(r);
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i > 0) @(negedge clk);
      obs = sample();
      n_checks++;
      if (obs !== exp_q[i])
        $display("FAIL %s cyc%0d: got %h expected %h", tag, i + 1, obs, exp_q[i]);
      else
        n_pass++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstN = 1'b0;
    key_valid = 1'b0;
    model_reset();
    @(negedge clk);
    rstN = 1'b1;
  endtask

  task automatic test_reset();
    obs_t obs;
    rstN = 1'b0;
    model_reset();
    @(negedge clk);
    obs = sample();
    n_checks++;
    if (obs !== '0) $display("FAIL reset_state: got %h expected 0", obs);
    else n_pass++;
    rstN = 1'b1;
    exec_cmd(0, 3, "first_push");
  endtask

  task automatic test_add();
    do_reset();
    exec_cmd(0, 3, "add_p3");
    exec_cmd(0, 5, "add_p5");
    exec_cmd(1, 0, "add");
    n_checks++;
    if (result !== 4'h8 || level !== 4'd1)
      $display("FAIL add_result: got r=%h l=%0d expected r=8 l=1", result, level);
    else n_pass++;
  endtask

  task automatic test_sub_wrap_xor();
    do_reset();
    exec_cmd(0, 2, "sub_p2");
    exec_cmd(0, 7, "sub_p7");
    exec_cmd(2, 0, "sub");
    n_checks++;
    if (result !== 4'hB) $display("FAIL sub_order: got %h expected b", result);
    else n_pass++;
    exec_cmd(0, 15, "wrap_pf");
    exec_cmd(0, 2, "wrap_p2");
    exec_cmd(1, 0, "wrap_add");
    n_checks++;
    if (result !== 4'h1) $display("FAIL add_wrap: got %h expected 1", result);
    else n_pass++;
    exec_cmd(0, 10, "xor_pa");
    exec_cmd(0, 6, "xor_p6");
    exec_cmd(3, 0, "xor");
    n_checks++;
    if (result !== 4'hC) $display("FAIL xor: got %h expected c", result);
    else n_pass++;
  endtask

  task automatic test_underflow();
    do_reset();
    exec_cmd(0, 4, "uf_p4");
    exec_cmd(1, 0, "uf_add");
    n_checks++;
    if (err_code !== 2'b10 || level !== 4'd1 || result !== 4'h0)
      $display("FAIL underflow: got code=%b l=%0d r=%h expected code=10 l=1 r=0",
               err_code, level, result);
    else n_pass++;
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < DEPTH; i++) exec_cmd(0, i + 1, "of_fill");
    exec_cmd(0, 9, "of_push9");
    n_checks++;
    if (err_code !== 2'b01 || level !== 4'd8)
      $display("FAIL overflow: got code=%b l=%0d expected code=01 l=8", err_code, level);
    else n_pass++;
    exec_cmd(1, 0, "of_add");
    n_checks++;
    if (level !== 4'd7) $display("FAIL overflow_add: got l=%0d expected 7", level);
    else n_pass++;
  endtask

  task automatic test_busy_drop();
    int exp_r;
    do_reset();
    exec_cmd(0, 3, "bd_p3");
    exec_cmd(0, 5, "bd_p5");
    exp_r = ref_op(1, 3, 5);
    key_valid = 1'b1; key_op = 2'b01;
    @(negedge clk);
    key_op = 2'b00; key_num = 4'h1;
    @(negedge clk);
    key_valid = 1'b0;
    n_checks++;
    if (err !== 1'b1 || err_code !== 2'b11 || stk_bus.pop !== 1'b1 || busy !== 1'b1)
      $display("FAIL busy_drop_err: got err=%b code=%b pop=%b expected 1 11 1",
               err, err_code, stk_bus.pop);
    else n_pass++;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (stk_bus.push !== 1'b1 || stk_bus.din !== 4'(exp_r) || result_valid !== 1'b1)
      $display("FAIL busy_drop_push: got push=%b din=%h rv=%b expected 1 %h 1",
               stk_bus.push, stk_bus.din, result_valid, exp_r);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || level !== 4'd1 || err !== 1'b0 || stk_bus.push !== 1'b0)
      $display("FAIL busy_drop_end: got busy=%b l=%0d err=%b expected 0 1 0",
               busy, level, err);
    else n_pass++;
    void'(q.pop_back());
    void'(q.pop_back());
    q.push_back(exp_r);
    last_result = exp_r;
    last_code   = 3;
    exec_cmd(1, 0, "bd_no_literal");
  endtask

  task automatic test_mid_reset();
    do_reset();
    exec_cmd(0, 1, "mr_p1a");
    exec_cmd(0, 1, "mr_p1b");
    exec_cmd(1, 0, "mr_add");
    exec_cmd(0, 3, "mr_p3");
    exec_cmd(0, 4, "mr_p4");
    key_valid = 1'b1; key_op = 2'b01;
    @(negedge clk);
    key_valid = 1'b0;
    @(negedge clk);
    #1 rstN = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if (busy !== 1'b0 || stk_bus.pop !== 1'b0 || level !== 4'd0 || result !== 4'h0)
      $display("FAIL mid_reset: got busy=%b pop=%b l=%0d r=%h expected 0 0 0 0",
               busy, stk_bus.pop, level, result);
    else n_pass++;
    @(negedge clk);
    rstN = 1'b1;
    exec_cmd(0, 6, "mr_p6");
    n_checks++;
    if (level !== 4'd1) $display("FAIL mid_reset_push: got l=%0d expected 1", level);
    else n_pass++;
  endtask

  task automatic test_random();
    int op;
    do_reset();
    for (int i = 0; i < 80; i++) begin
      op = ($urandom_range(0, 9) < 5) ? 0 : int'($urandom_range(1, 3));
      exec_cmd(op, int'($urandom_range(0, 15)), "random");
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 4; i++) exec_cmd(0, 15 - i, "b2b_push");
    exec_cmd(2, 0, "b2b_sub");
    exec_cmd(3, 0, "b2b_xor");
    exec_cmd(1, 0, "b2b_add");
    exec_cmd(1, 0, "b2b_underflow");
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_wrap_xor();
    test_underflow();
    test_overflow();
    test_busy_drop();
    test_mid_reset();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rpn_ctrl.md
# rpn_ctrl

Command sequencer that sits directly upstream of the 8-deep, 4-bit stack and drives its push/pop/data_in port, turning key-style commands into stack traffic. Literal commands push a nibble. Arithmetic commands pop two operands, compute a 4-bit result, and push it back. It tracks stack occupancy itself, so underflow, overflow and busy conditions are rejected before any stack strobe is issued.

## Interface
- DEPTH, 8, stack depth; must match the stack instance
- W, 4, data width
- clk  in  1  system clock, rising edge
- rstN  in  1  reset, asynchronous, active-low; shared with the stack instance
- key_valid  in  1  one-cycle command strobe
- key_op  in  2  00 PUSH literal, 01 ADD, 10 SUB, 11 XOR
- key_num  in  W  literal for PUSH; ignored otherwise
- stk_push  out  1  push strobe to stack
- stk_pop  out  1  pop strobe to stack
- stk_din  out  W  data to stack
- stk_dout  in  W  stack output register; valid the cycle after a pop
- stk_full  in  1  stack full flag; informational, not used for decisions
- stk_empty  in  1  stack empty flag; informational, not used for decisions
- busy  out  1  high whenever the FSM is not in IDLE
- level  out  $clog2(DEPTH+1)  internal occupancy count
- result  out  W  last arithmetic result; holds until overwritten
- result_valid  out  1  one-cycle pulse when result updates
- err  out  1  one-cycle pulse on a rejected command
- err_code  out  2  last error: 01 overflow, 10 underflow, 11 busy-drop; holds until next error or reset

## Operation
- States: IDLE, PUSH_LIT, POP1, POP2, CAP2, PUSH_RES.
- IDLE with key_valid=1 and PUSH:
  - If level==DEPTH: overflow error, stay IDLE.
  - Else: register key_num, go to PUSH_LIT.
- IDLE with key_valid=1 and an arithmetic op:
  - If level<2: underflow error, stay IDLE.
  - Else: register op, go to POP1.
- PUSH_LIT: stk_push=1, stk_din=latched literal, level+1 -> IDLE.
- POP1: stk_pop=1, level-1 -> POP2.
- POP2: stk_pop=1, level-1, capture b=stk_dout (top of stack) -> CAP2.
- CAP2: capture a=stk_dout (second operand) -> PUSH_RES.
- PUSH_RES: stk_push=1, stk_din=f(a,b), level+1, result<=f(a,b), result_valid=1 -> IDLE.
- f is ADD a+b, SUB a-b (a = deeper operand), XOR a^b. All are modulo 2^W; carry and borrow are discarded.
- Rejected commands issue no stack strobe, leave level unchanged, and pulse err for one cycle.
- key_valid while busy=1: command dropped, err pulse with err_code 11, current operation continues unaffected.
- stk_push and stk_pop are never high in the same cycle. Each is a single-cycle pulse.
- stk_din is 0 in every cycle where stk_push=0.

## Timing
- Reset (rstN low, asynchronous): state IDLE.
- Outputs during reset: stk_push, stk_pop, stk_din, busy, level, result, result_valid, err and err_code all read 0.
- Reset release: first command may be accepted on the first rising edge after rstN goes high.
- Command accepted at edge 0 is the rising edge where key_valid=1 in IDLE.
- Literal push: stk_push high in cycle 1; busy high in cycle 1 only; next command accepted at edge 2.
- Arithmetic command, per cycle:
  - Cycle 1: pop.
  - Cycle 2: pop, plus capture of b.
  - Cycle 3: capture of a.
  - Cycle 4: push, with result_valid.
  - busy is high for cycles 1-4; next command accepted at edge 5.
- err is asserted in cycle 1, i.e. the cycle after the offending strobe.
- level updates at the same edge that ends the strobe cycle.
- Reset asserted mid-operation: immediate return to IDLE with all outputs 0. The stack is reset by the same rstN, so level=0 stays consistent with it.
- Net effect of an arithmetic op on level is -1. level never exceeds DEPTH and never goes below 0.

## Test plan
- Two literal pushes and an ADD: PUSH 3, PUSH 5, ADD -> stk_pop pulses in cycles 1-2 of the ADD, stk_push with stk_din=8 in cycle 4, result=8, result_valid pulse, level=1.
- SUB ordering and wrap: PUSH 2, PUSH 7, SUB -> result=0xB (2-7 mod 16); then PUSH F, PUSH 2, ADD -> result=1; XOR of 0xA and 0x6 -> 0xC.
- Underflow: after reset, PUSH 4, then ADD -> err pulse with err_code=10, no stk_pop, level stays 1, result stays 0.
- Overflow: 8 PUSHes (level=8, stk_full=1), then PUSH 9 -> err_code=01, no stk_push, level stays 8; a following ADD succeeds and gives level=7.
- Busy-drop: ADD accepted, key_valid with PUSH 1 one cycle later -> err_code=11, the ADD completes normally, and the literal is never pushed.
- Mid-operation reset: rstN low during POP2 -> same cycle busy=0, stk_pop=0, level=0, result=0; after release, PUSH 6 pushes normally and level=1.
